// File: rtl/rd_ptr_ctrl_fwft_if.sv
// Consumer-side valid/ready handshake of the FIFO read port.
//   o_rvalid : head word on o_rdata is valid (driven by the controller)
//   o_rdata  : head-of-FIFO word, first-word-fall-through
//   i_rready : consumer accepts the head word this cycle
// Signal names keep the controller's point of view (i_ = into controller).
interface rd_ptr_ctrl_fwft_if #(
  parameter int DATA_W = 8
);
  logic              i_rready;
  logic              o_rvalid;
  logic [DATA_W-1:0] o_rdata;

  // Controller side: produces the data and valid flag.
  modport master (
    output o_rvalid,
    output o_rdata,
    input  i_rready
  );

  // Consumer side: observes data and valid, drives ready.
  modport slave (
    input  o_rvalid,
    input  o_rdata,
    output i_rready
  );
endinterface

// File: rtl/rd_ptr_ctrl_fwft.sv
// Read-domain controller of the async FIFO.
// Owns the binary/gray read pointer and the registered memory-empty flag,
// drives the 1-cycle-latency synchronous RAM read port and presents words
// first-word-fall-through through a 2-entry (head + skid) output buffer.
// Ports:
//   i_rclk, i_rrst   read clock, asynchronous active-high reset
//   i_g_wptr_sync    gray write pointer, already synchronised into i_rclk
//   rd_if            consumer handshake (o_rvalid / o_rdata / i_rready)
//   o_ren, o_raddr   RAM read enable (combinational) and address
//   i_mem_rdata      RAM read data, valid the cycle after o_ren
//   o_g_rptr         registered gray read pointer for the write domain
//   o_mem_empty      registered: no unfetched words left in the RAM
//   o_rlevel         registered: words not yet popped (RAM + in flight + buffer)
//   o_almost_empty   registered: o_rlevel <= AE_THRESH
module rd_ptr_ctrl_fwft #(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int DATA_W    = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                i_rclk,
  input  logic                i_rrst,
  input  logic [PTR_W:0]      i_g_wptr_sync,
  rd_ptr_ctrl_fwft_if.master  rd_if,
  output logic                o_ren,
  output logic [PTR_W-1:0]    o_raddr,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [PTR_W:0]      o_g_rptr,
  output logic                o_mem_empty,
  output logic [PTR_W:0]      o_rlevel,
  output logic                o_almost_empty
);

  localparam logic [PTR_W:0] AE_LVL = AE_THRESH[PTR_W:0];

  function automatic logic [PTR_W:0] bin2gray(input logic [PTR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W:0] gray2bin(input logic [PTR_W:0] g);
    logic [PTR_W:0] b;
    b[PTR_W] = g[PTR_W];
    for (int i = PTR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // State registers
  logic [PTR_W:0]    b_rptr_q, b_rptr_d;
  logic [PTR_W:0]    g_rptr_q, g_rptr_d;
  logic              mem_empty_q, mem_empty_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rvalid_q, rvalid_d;
  logic [PTR_W:0]    level_q, level_d;
  logic              ae_q, ae_d;

  // Combinational helpers
  logic              pop_s;
  logic              load_s;
  logic              issue_s;
  logic [2:0]        occ_s;

  // Next-state logic: fetch decision, pointer advance, buffer moves, level.
  always_comb begin
    pop_s    = rvalid_q & rd_if.i_rready;
    load_s   = inflight_q;
    // Occupancy left after this cycle's pop; pop implies buf_cnt >= 1 so no underflow.
    occ_s    = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    // Fetch only when the buffer can absorb the word returning next cycle.
    issue_s  = ~mem_empty_q & (occ_s <= 3'd1);

    b_rptr_d    = b_rptr_q + {{PTR_W{1'b0}}, issue_s};
    g_rptr_d    = bin2gray(b_rptr_d);
    // Empty is a plain gray equality (no MSB inversion as used for full).
    mem_empty_d = (g_rptr_d == i_g_wptr_sync);
    inflight_d  = issue_s;

    head_d = head_q;
    skid_d = skid_q;
    if (load_s && (buf_cnt_q == 2'd0)) begin
      head_d = i_mem_rdata;
    end else if (load_s && !pop_s && (buf_cnt_q == 2'd1)) begin
      skid_d = i_mem_rdata;
    end else if (load_s && pop_s && (buf_cnt_q == 2'd1)) begin
      head_d = i_mem_rdata;
    end else if (!load_s && pop_s && (buf_cnt_q == 2'd2)) begin
      head_d = skid_q;
    end else begin
      head_d = head_q;
      skid_d = skid_q;
    end

    buf_cnt_d = buf_cnt_q + {1'b0, load_s} - {1'b0, pop_s};
    rvalid_d  = (buf_cnt_d != 2'd0);

    // Everything written but not yet popped: unfetched RAM words plus in-flight plus buffered.
    level_d = (gray2bin(i_g_wptr_sync) - b_rptr_d)
              + {{(PTR_W-1){1'b0}}, buf_cnt_d}
              + {{PTR_W{1'b0}}, inflight_d};
    ae_d    = (level_d <= AE_LVL);
  end

  // State update with asynchronous reset; reset drops any in-flight or buffered word.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      b_rptr_q    <= {(PTR_W+1){1'b0}};
      g_rptr_q    <= {(PTR_W+1){1'b0}};
      mem_empty_q <= 1'b1;
      inflight_q  <= 1'b0;
      buf_cnt_q   <= 2'd0;
      head_q      <= {DATA_W{1'b0}};
      skid_q      <= {DATA_W{1'b0}};
      rvalid_q    <= 1'b0;
      level_q     <= {(PTR_W+1){1'b0}};
      ae_q        <= 1'b1;
    end else begin
      b_rptr_q    <= b_rptr_d;
      g_rptr_q    <= g_rptr_d;
      mem_empty_q <= mem_empty_d;
      inflight_q  <= inflight_d;
      buf_cnt_q   <= buf_cnt_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      rvalid_q    <= rvalid_d;
      level_q     <= level_d;
      ae_q        <= ae_d;
    end
  end

  assign o_ren          = issue_s;
  assign o_raddr        = b_rptr_q[PTR_W-1:0];
  assign o_g_rptr       = g_rptr_q;
  assign o_mem_empty    = mem_empty_q;
  assign o_rlevel       = level_q;
  assign o_almost_empty = ae_q;
  assign rd_if.o_rvalid = rvalid_q;
  assign rd_if.o_rdata  = head_q;

endmodule

// File: tb/tb_rd_ptr_ctrl_fwft.sv
// Self-checking bench for rd_ptr_ctrl_fwft: a RAM model, a writer that
// advances the gray write pointer, and a queue-based reference model.
module tb_rd_ptr_ctrl_fwft;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] g_w = 5'd0;
  logic       ren;
  logic [3:0] raddr;
  logic [7:0] mem_rdata = 8'd0;
  logic [4:0] g_rptr;
  logic       mem_empty;
  logic [4:0] rlevel;
  logic       almost_empty;

  rd_ptr_ctrl_fwft_if #(.DATA_W(8)) rif ();

  rd_ptr_ctrl_fwft dut (
    .i_rclk         (clk),
    .i_rrst         (rst),
    .i_g_wptr_sync  (g_w),
    .rd_if          (rif),
    .o_ren          (ren),
    .o_raddr        (raddr),
    .i_mem_rdata    (mem_rdata),
    .o_g_rptr       (g_rptr),
    .o_mem_empty    (mem_empty),
    .o_rlevel       (rlevel),
    .o_almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  // RAM model: one cycle read latency
  always @(posedge clk) begin
    if (ren) mem_rdata <= mem[raddr];
  end

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [4:0] wptr, popped, fetch_cnt, exp_level, prev_g;
  logic [7:0] hold_data;
  bit         hold_pending, last_pop, last_ren;
  int         pops_total, fetch_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wptr = 5'd0; popped = 5'd0; fetch_cnt = 5'd0; exp_level = 5'd0; prev_g = 5'd0;
    hold_pending = 1'b0; hold_data = 8'd0; last_pop = 1'b0; last_ren = 1'b0;
    g_w = 5'd0;
  endtask

  // One clock cycle: check registered outputs, then drive inputs for the next edge.
  task automatic step(input bit wr, input bit rdy, input logic [7:0] d);
    logic [4:0] used;
    @(negedge clk);
    check("level", rlevel, exp_level);
    check("almost_empty", almost_empty, (exp_level <= 5'd2));
    check("g_rptr", g_rptr, fetch_cnt ^ (fetch_cnt >> 1));
    if (g_rptr != prev_g) check("g_one_bit", $countones(g_rptr ^ prev_g), 1);
    prev_g = g_rptr;
    if (hold_pending) begin
      check("hold_valid", rif.o_rvalid, 1'b1);
      check("hold_data", rif.o_rdata, hold_data);
    end
    used = wptr - popped;
    if (wr && (used < 5'd16)) begin
      mem[wptr[3:0]] = d;
      q.push_back(d);
      wptr = wptr + 5'd1;
      g_w = wptr ^ (wptr >> 1);
    end
    rif.i_rready = rdy;
    #1;
    last_ren = ren;
    if (ren) begin
      check("raddr", raddr, fetch_cnt[3:0]);
      fetch_cnt = fetch_cnt + 5'd1;
      fetch_total++;
    end
    last_pop = rif.o_rvalid & rdy;
    if (last_pop) begin
      if (q.size() == 0) check("pop_underflow", 1, 0);
      else check("data", rif.o_rdata, q.pop_front());
      popped = popped + 5'd1;
      pops_total++;
    end
    hold_pending = rif.o_rvalid & ~rdy;
    hold_data    = rif.o_rdata;
    exp_level    = wptr - popped;
  endtask

  initial begin
    int start;
    int guard;
    rif.i_rready = 1'b0;
    pops_total = 0; fetch_total = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset state, idle with empty write pointer
    repeat (3) step(1'b0, 1'b0, 8'h00);
    check("t1_empty", mem_empty, 1'b1);
    check("t1_rvalid", rif.o_rvalid, 1'b0);
    check("t1_ren", ren, 1'b0);
    check("t1_level", rlevel, 5'd0);
    check("t1_ae", almost_empty, 1'b1);

    // 2: single word latency
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b0, 8'h00);
    check("t2_ren", last_ren, 1'b1);
    check("t2_rvalid_n1", rif.o_rvalid, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("t2_rvalid_n2", rif.o_rvalid, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("t2_rvalid", rif.o_rvalid, 1'b1);
    check("t2_rdata", rif.o_rdata, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    check("t2_pop", last_pop, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check("t2_rvalid_after", rif.o_rvalid, 1'b0);
    check("t2_g_rptr", g_rptr, 5'd1);

    // 3: burst of 16 with consumer stalled, then drain without bubbles
    rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, i[7:0]);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check("t3_reads", fetch_cnt, 5'd2);
    check("t3_rvalid", rif.o_rvalid, 1'b1);
    check("t3_level", rlevel, 5'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("t3_nobubble", last_pop, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00);
    check("t3_level_end", rlevel, 5'd0);

    // 4: random backpressure over 100 words
    start = pops_total;
    guard = 0;
    while ((pops_total - start) < 100 && guard < 3000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 8'($urandom));
      guard++;
    end
    check("t4_done", (pops_total - start) >= 100, 1'b1);

    // 5: pointer wrap while streaming 40 words at full rate
    start = fetch_total;
    guard = 0;
    while ((fetch_total - start) < 40 && guard < 300) begin
      step(1'b1, 1'b1, 8'($urandom));
      guard++;
    end
    check("t5_done", (fetch_total - start) >= 40, 1'b1);
    repeat (20) step(1'b0, 1'b1, 8'h00);
    check("t5_drained", q.size(), 0);

    // 6: asynchronous reset with a full output buffer
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check("t6_full", rif.o_rvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_rvalid", rif.o_rvalid, 1'b0);
    check("t6_rdata", rif.o_rdata, 8'h00);
    check("t6_empty", mem_empty, 1'b1);
    check("t6_level", rlevel, 5'd0);
    check("t6_ae", almost_empty, 1'b1);
    check("t6_g_rptr", g_rptr, 5'd0);
    check("t6_ren", ren, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("t6_no_stale", rif.o_rvalid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
